// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// One shift-add (multiply) or restoring-divide step per cycle; results carry sign fix-up.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc;

    logic               launch;
    logic               finish;
    logic               wr_ok;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nx;
    logic [WIDTH:0]     div_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub;
    logic [2*WIDTH-1:0] div_nx;
    logic [2*WIDTH-1:0] acc_nx;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic               zero_div;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        launch   = 1'b0;
        finish   = 1'b0;
        wr_ok    = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                wr_ok = 1'b1;
                if (start) begin
                    launch   = 1'b1;
                    state_nx = S_CALC;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_CALC: begin
                if (cnt == CW'(1)) begin
                    finish   = 1'b1;
                    state_nx = S_DONE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Operand magnitudes; the most-negative value maps onto itself, which is the correct unsigned magnitude.
    always_comb begin
        a_neg = op[0] & a[WIDTH-1];
        b_neg = op[0] & b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
        mul_nx  = {mul_sum, acc[WIDTH-1:1]};

        div_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge  = div_sh >= {1'b0, mag_b};
        div_sub = div_sh[WIDTH-1:0] - mag_b;
        div_nx  = {(div_ge ? div_sub : div_sh[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};

        acc_nx   = is_div ? div_nx : mul_nx;
        prod_neg = -acc_nx;
        quo      = acc_nx[WIDTH-1:0];
        rem      = acc_nx[2*WIDTH-1:WIDTH];
        zero_div = is_div && (mag_b == '0);

        if (is_div) begin
            res_lo = neg_res ? -quo : quo;
            res_hi = neg_rem ? -rem : rem;
        end else if (neg_res) begin
            res_lo = prod_neg[WIDTH-1:0];
            res_hi = prod_neg[2*WIDTH-1:WIDTH];
        end else begin
            res_lo = acc_nx[WIDTH-1:0];
            res_hi = acc_nx[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            is_div      <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            mag_b       <= '0;
            acc         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            busy <= (state_nx == S_CALC);
            done <= (state_nx == S_DONE);

            if (launch) begin
                is_div  <= op[1];
                neg_res <= a_neg ^ b_neg;
                neg_rem <= a_neg;
                mag_b   <= b_mag;
                acc     <= {{WIDTH{1'b0}}, a_mag};
                cnt     <= CW'(WIDTH);
            end else if (state == S_CALC) begin
                acc <= acc_nx;
                cnt <= cnt - CW'(1);
            end

            // Result load and mthi/mtlo are mutually exclusive: writes are only honoured outside CALC.
            if (finish) begin
                div_by_zero <= zero_div;
                if (!zero_div) begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
            end else if (wr_ok) begin
                if (hi_we) begin
                    hi <= wd;
                end
                if (lo_we) begin
                    lo <= wd;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus hand-written multi-cycle sequences.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int total;
    int bad;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .op(op),
        .a(a),
        .b(b),
        .hi_we(hi_we),
        .lo_we(lo_we),
        .wd(wd),
        .busy(busy),
        .done(done),
        .div_by_zero(div_by_zero),
        .hi(hi),
        .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; start is seen on the next edge, then operands are scrambled.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Sample index 1 is the cycle right after the start edge.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 1;
        bcnt = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (busy === 1'b1) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int dcnt;
        int dlat;

        total = 0;
        bad   = 0;
        clk   = 1'b0;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wd    = '0;

        vecs[0] = '{op: 2'b00, a: 32'd7,          b: 32'd6,          hi: 32'h0000_0000, lo: 32'h0000_002A, dbz: 1'b0};
        vecs[1] = '{op: 2'b01, a: 32'hFFFF_FFFD,  b: 32'd5,          hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFF1, dbz: 1'b0};
        vecs[2] = '{op: 2'b00, a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  hi: 32'hFFFF_FFFE, lo: 32'h0000_0001, dbz: 1'b0};
        vecs[3] = '{op: 2'b11, a: 32'hFFFF_FFF9,  b: 32'd2,          hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD, dbz: 1'b0};
        vecs[4] = '{op: 2'b11, a: 32'h8000_0000,  b: 32'hFFFF_FFFF,  hi: 32'h0000_0000, lo: 32'h8000_0000, dbz: 1'b0};
        vecs[5] = '{op: 2'b10, a: 32'd100,        b: 32'd7,          hi: 32'd2,         lo: 32'd14,        dbz: 1'b0};
        vecs[6] = '{op: 2'b01, a: 32'h8000_0000,  b: 32'h8000_0000,  hi: 32'h4000_0000, lo: 32'h0000_0000, dbz: 1'b0};
        vecs[7] = '{op: 2'b11, a: 32'd7,          b: 32'hFFFF_FFFE,  hi: 32'd1,         lo: 32'hFFFF_FFFD, dbz: 1'b0};
        vecs[8] = '{op: 2'b10, a: 32'd5,          b: 32'd9,          hi: 32'd5,         lo: 32'd0,         dbz: 1'b0};
        vecs[9] = '{op: 2'b00, a: 32'h1234_5678,  b: 32'h0000_0100,  hi: 32'h0000_0012, lo: 32'h3456_7800, dbz: 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset dbz", 32'(div_by_zero), 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // mtlo, mthi, then divide by zero leaves them intact
        lo_we = 1'b1;
        wd    = 32'h1234;
        @(posedge clk);
        #1;
        lo_we = 1'b0;
        hi_we = 1'b1;
        wd    = 32'h5678;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        check("mtlo", lo, 32'h1234);
        check("mthi", hi, 32'h5678);
        issue(2'b10, 32'd100, 32'd0);
        wait_done(lat, bcnt);
        check("dbz latency", 32'(lat), 32'd33);
        check("dbz flag", 32'(div_by_zero), 32'd1);
        check("dbz hi", hi, 32'h5678);
        check("dbz lo", lo, 32'h1234);
        repeat (3) @(posedge clk);
        #1;
        check("dbz hold", 32'(div_by_zero), 32'd1);

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat, bcnt);
            check($sformatf("v%0d latency", i), 32'(lat), 32'd33);
            check($sformatf("v%0d busy cycles", i), 32'(bcnt), 32'd32);
            check($sformatf("v%0d hi", i), hi, vecs[i].hi);
            check($sformatf("v%0d lo", i), lo, vecs[i].lo);
            check($sformatf("v%0d dbz", i), 32'(div_by_zero), 32'(vecs[i].dbz));
            @(posedge clk);
            #1;
            check($sformatf("v%0d done pulse", i), 32'(done), 32'd0);
            check($sformatf("v%0d idle", i), 32'(busy), 32'd0);
        end

        // start and mthi mid-CALC must be ignored
        issue(2'b00, 32'd3, 32'd4);
        dcnt = 0;
        dlat = 0;
        for (int i = 1; i <= 45; i++) begin
            if (done === 1'b1) begin
                dcnt++;
                if (dlat == 0) dlat = i;
            end
            if (i == 7) check("busy hi unchanged", hi, vecs[9].hi);
            if (i == 5) begin
                start = 1'b1;
                op    = 2'b10;
                a     = 32'd100;
                b     = 32'd3;
                hi_we = 1'b1;
                wd    = 32'hDEAD;
            end else if (i == 6) begin
                start = 1'b0;
                hi_we = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        check("busy done count", 32'(dcnt), 32'd1);
        check("busy done latency", 32'(dlat), 32'd33);
        check("busy hi", hi, 32'd0);
        check("busy lo", lo, 32'd12);

        // mtlo in the same cycle as start, then overwritten by the result
        op    = 2'b00;
        a     = 32'd1;
        b     = 32'd1;
        start = 1'b1;
        lo_we = 1'b1;
        wd    = 32'h77;
        @(posedge clk);
        #1;
        start = 1'b0;
        lo_we = 1'b0;
        check("start+mtlo lo", lo, 32'h77);
        wait_done(lat, bcnt);
        check("start+mtlo latency", 32'(lat), 32'd33);
        check("start+mtlo result", lo, 32'd1);

        // mthi during DONE overrides the fresh result
        issue(2'b00, 32'd2, 32'd2);
        wait_done(lat, bcnt);
        check("done-mthi lo", lo, 32'd4);
        hi_we = 1'b1;
        wd    = 32'hBEEF;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        check("done-mthi hi", hi, 32'hBEEF);
        check("done-mthi idle", 32'(busy), 32'd0);

        // back-to-back: new start during the DONE cycle
        issue(2'b00, 32'd5, 32'd5);
        wait_done(lat, bcnt);
        check("b2b first lo", lo, 32'd25);
        issue(2'b10, 32'd9, 32'd4);
        check("b2b busy", 32'(busy), 32'd1);
        wait_done(lat, bcnt);
        check("b2b latency", 32'(lat), 32'd33);
        check("b2b lo", lo, 32'd2);
        check("b2b hi", hi, 32'd1);

        // asynchronous reset in the middle of a mult
        issue(2'b01, 32'hFFFF_FFFD, 32'd5);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        check("pre-reset busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async rst busy", 32'(busy), 32'd0);
        check("async rst done", 32'(done), 32'd0);
        check("async rst hi", hi, 32'd0);
        check("async rst lo", lo, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("post-rst idle", 32'(busy), 32'd0);
        check("post-rst done", 32'(done), 32'd0);
        issue(2'b00, 32'd2, 32'd3);
        wait_done(lat, bcnt);
        check("post-rst latency", 32'(lat), 32'd33);
        check("post-rst lo", lo, 32'd6);
        check("post-rst hi", hi, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers. It sits beside the single-cycle ALU and executes MIPS mult, multu, div and divu as multi-cycle operations, one bit per cycle. It also supports mthi/mtlo writes. The issuing control stalls on busy and samples hi/lo after done.

Parameters:
WIDTH, 32, operand width; hi and lo are each WIDTH bits; must be >= 2.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  request a new operation; sampled only when not busy
op  input  2  00 multu, 01 mult, 10 divu, 11 div
a  input  WIDTH  multiplicand / dividend (rs)
b  input  WIDTH  multiplier / divisor (rt)
hi_we  input  1  mthi: write wd into hi
lo_we  input  1  mtlo: write wd into lo
wd  input  WIDTH  data for hi_we/lo_we
busy  output  1  operation in progress; start/hi_we/lo_we ignored
done  output  1  one-cycle pulse: operation finished, hi/lo valid
div_by_zero  output  1  valid with done; 1 when a divide had b == 0
hi  output  WIDTH  HI register (product upper half / remainder)
lo  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset (async, any state, including mid-operation): state IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0; iteration counter, operand and sign registers cleared. Any partial operation is discarded.
- States: IDLE, CALC, DONE. All outputs are registered.
- IDLE or DONE, start=1 at edge k:
  - op, |a|, |b| and the result signs are latched. Signed ops use the magnitude of each operand; unsigned ops use the operands as-is.
  - Counter is loaded with WIDTH; next state is CALC.
- CALC: one iteration per cycle.
  - Multiply: shift-add, 2*WIDTH-bit accumulator.
  - Divide: restoring, WIDTH-bit partial remainder.
  - Counter decrements each cycle. The cycle in which counter==1 is the last; next state is DONE.
- Timing: busy=1 for cycles k+1 .. k+WIDTH. At edge k+WIDTH, hi/lo are loaded with the final result. done=1 and busy=0 for exactly cycle k+WIDTH+1. With WIDTH=32 that is 33 cycles from the start edge to done.
- DONE lasts one cycle, then returns to IDLE unless start is seen, in which case it goes straight to CALC (back-to-back operations). div_by_zero holds its value until the next done or reset.
- Sign fix-up:
  - mult: the 2*WIDTH-bit product is negated if the operand signs differ.
  - div: the quotient is negated if the signs differ; the remainder takes the sign of the dividend.
  - Unsigned ops: no fix-up.
- Most-negative / -1 divide (div, a = 1<<(WIDTH-1), b = all ones): lo = 1<<(WIDTH-1), hi = 0. This falls naturally out of the magnitude arithmetic; no trap is raised.
- Divide by zero (divu/div with b=0): normal CALC latency; hi and lo are NOT updated; div_by_zero=1 with done. Multiplies always give div_by_zero=0.
- Ops while busy:
  - start is ignored; the operation in flight is unaffected.
  - hi_we and lo_we are ignored.
- hi_we/lo_we when not busy: hi <= wd and/or lo <= wd on the edge.
  - If start is in the same cycle, the write still happens; the later result overwrites it.
  - In DONE the writes are allowed and override the just-written result on the following edge.
- Operands a and b need not be held after the start edge.

Test Plan:
- Multiply (WIDTH=32), unsigned and signed:
  - multu a=7, b=6 -> done exactly 33 cycles after the start edge, busy high for 32 cycles, hi=0x00000000, lo=0x0000002A.
  - mult a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - multu a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed divide:
  - div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- Divide by zero: mtlo 0x1234, then mthi 0x5678, then divu a=100, b=0 -> done after 33 cycles, div_by_zero=1, hi=0x5678, lo=0x1234.
- Busy blocking: during a multu of 3*4, pulse start with op=divu and pulse hi_we with wd=0xDEAD mid-CALC -> both ignored; result is hi=0, lo=12; exactly one done pulse.
- Back-to-back: assert start with divu a=9, b=4 during the DONE cycle of a prior op -> the new operation starts immediately; done 33 cycles later with lo=2, hi=1.
- Reset: assert rst 10 cycles into a mult -> busy, done, hi, lo all drop to 0 asynchronously (before the next clk edge); after release the unit is idle and a fresh multu 2*3 gives lo=6.
